// File: rtl/ad7265_ctrl.sv
// AD7265 initiator: scans channels 0..NUM_CH-1, shifts in both 32-bit DOUT frames, publishes the A/B pair.
// Latency: result_valid pulses on the first ncs-high clk after a frame; frame = 65*CLK_DIV clks low + QUIET_CYC high.
// Backpressure: none; each result is a one-clk strobe and is overwritten by the next frame.
//
// Ports:
//   clk, rst_n                    system clock, async active-low reset
//   en, cfg_rng, cfg_sgl          scan enable and range/mode, all sampled only at frame boundaries
//   ncs, adc_sclk, adc_addr,      ADC control pins (registered)
//   rng, sgl
//   douta, doutb                  ADC serial data, MSB first
//   result_valid, result_addr,    published conversion pair; mismatch flags a frame whose
//   result_a, result_b, mismatch  duplicated copies or zero pads do not agree
module ad7265_ctrl #(
    parameter int CLK_DIV   = 2,
    parameter int QUIET_CYC = 8,
    parameter int NUM_CH    = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        cfg_rng,
    input  logic        cfg_sgl,
    output logic        ncs,
    output logic        adc_sclk,
    output logic [2:0]  adc_addr,
    output logic        rng,
    output logic        sgl,
    input  logic        douta,
    input  logic        doutb,
    output logic        result_valid,
    output logic [2:0]  result_addr,
    output logic [11:0] result_a,
    output logic [11:0] result_b,
    output logic        mismatch
);

    // One counter serves both the SCLK half-period and the quiet gap.
    localparam int CNT_MAX = (CLK_DIV > QUIET_CYC) ? CLK_DIV : QUIET_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] QUIET_LAST = CNT_W'(QUIET_CYC - 1);
    localparam logic [2:0]       ADDR_LAST  = 3'(NUM_CH - 1);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, QUIET} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [5:0]       edge_q, edge_d;   // number of SCLK falling edges issued this frame
    logic [31:0]      sa_q, sa_d;
    logic [31:0]      sb_q, sb_d;
    logic             ncs_q, ncs_d;
    logic             sclk_q, sclk_d;
    logic [2:0]       addr_q, addr_d;
    logic             rng_q, rng_d;
    logic             sgl_q, sgl_d;
    logic             rvld_q, rvld_d;
    logic [2:0]       raddr_q, raddr_d;
    logic [11:0]      ra_q, ra_d;
    logic [11:0]      rb_q, rb_d;
    logic             mism_q, mism_d;

    logic             frame_bad;
    logic [2:0]       next_addr;

    // Each DOUT line carries its own result in the top half and the other
    // channel's result in the bottom half; cross-check both copies and the pads.
    assign frame_bad = (sa_q[13:2] != sb_q[29:18]) ||
                       (sb_q[13:2] != sa_q[29:18]) ||
                       (|sa_q[31:30]) || (|sa_q[17:14]) || (|sa_q[1:0]) ||
                       (|sb_q[31:30]) || (|sb_q[17:14]) || (|sb_q[1:0]);

    assign next_addr = (addr_q == ADDR_LAST) ? 3'd0 : addr_q + 3'd1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        edge_d  = edge_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        ncs_d   = ncs_q;
        sclk_d  = sclk_q;
        addr_d  = addr_q;
        rng_d   = rng_q;
        sgl_d   = sgl_q;
        rvld_d  = 1'b0;
        raddr_d = raddr_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        mism_d  = mism_q;

        case (state_q)
            IDLE: begin
                ncs_d  = 1'b1;
                sclk_d = 1'b1;
                if (en) begin
                    state_d = SETUP;
                    ncs_d   = 1'b0;
                    rng_d   = cfg_rng;
                    sgl_d   = cfg_sgl;
                    cnt_d   = '0;
                end
            end

            SETUP: begin
                if (cnt_q == DIV_LAST) begin
                    // Bit 31 is already on DOUT after ncs falls; take it just before the first fall.
                    sa_d    = {sa_q[30:0], douta};
                    sb_d    = {sb_q[30:0], doutb};
                    sclk_d  = 1'b0;
                    edge_d  = 6'd1;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            SHIFT: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d = '0;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else if (edge_q == 6'd32) begin
                        // Trailing high phase done: publish and release the ADC.
                        state_d = QUIET;
                        ncs_d   = 1'b1;
                        rvld_d  = 1'b1;
                        raddr_d = addr_q;
                        ra_d    = sa_q[29:18];
                        rb_d    = sb_q[29:18];
                        mism_d  = frame_bad;
                        addr_d  = next_addr;
                    end else begin
                        // Sample at the end of the high phase, right before the next fall.
                        sa_d   = {sa_q[30:0], douta};
                        sb_d   = {sb_q[30:0], doutb};
                        sclk_d = 1'b0;
                        edge_d = edge_q + 6'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            QUIET: begin
                if (cnt_q == QUIET_LAST) begin
                    cnt_d = '0;
                    if (en) begin
                        state_d = SETUP;
                        ncs_d   = 1'b0;
                        rng_d   = cfg_rng;
                        sgl_d   = cfg_sgl;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            edge_q  <= '0;
            sa_q    <= '0;
            sb_q    <= '0;
            ncs_q   <= 1'b1;
            sclk_q  <= 1'b1;
            addr_q  <= '0;
            rng_q   <= 1'b0;
            sgl_q   <= 1'b0;
            rvld_q  <= 1'b0;
            raddr_q <= '0;
            ra_q    <= '0;
            rb_q    <= '0;
            mism_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            edge_q  <= edge_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            ncs_q   <= ncs_d;
            sclk_q  <= sclk_d;
            addr_q  <= addr_d;
            rng_q   <= rng_d;
            sgl_q   <= sgl_d;
            rvld_q  <= rvld_d;
            raddr_q <= raddr_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            mism_q  <= mism_d;
        end
    end

    assign ncs          = ncs_q;
    assign adc_sclk     = sclk_q;
    assign adc_addr     = addr_q;
    assign rng          = rng_q;
    assign sgl          = sgl_q;
    assign result_valid = rvld_q;
    assign result_addr  = raddr_q;
    assign result_a     = ra_q;
    assign result_b     = rb_q;
    assign mismatch     = mism_q;

endmodule

// File: tb/tb_ad7265_ctrl.sv
// Bench for ad7265_ctrl: behavioural AD7265 model driving both DOUT lines, result scoreboard.
// Two instances: defaults, and CLK_DIV=1 / NUM_CH=3.
// All expectations are hand-derived constants or the model's programmed channel data.
module tb_ad7265_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // default instance
    logic        rst_n, en, cfg_rng, cfg_sgl, douta, doutb;
    logic        ncs, adc_sclk, rng, sgl, result_valid, mismatch;
    logic [2:0]  adc_addr, result_addr;
    logic [11:0] result_a, result_b;

    // fast instance
    logic        rst2_n, en2, cfg_rng2, douta2, doutb2;
    logic        ncs2, sclk2, rng2, sgl2, rv2, mis2;
    logic [2:0]  addr2, raddr2;
    logic [11:0] ra2, rb2;

    ad7265_ctrl u_dut (
        .clk(clk), .rst_n(rst_n), .en(en), .cfg_rng(cfg_rng), .cfg_sgl(cfg_sgl),
        .ncs(ncs), .adc_sclk(adc_sclk), .adc_addr(adc_addr), .rng(rng), .sgl(sgl),
        .douta(douta), .doutb(doutb), .result_valid(result_valid),
        .result_addr(result_addr), .result_a(result_a), .result_b(result_b),
        .mismatch(mismatch)
    );

    ad7265_ctrl #(.CLK_DIV(1), .QUIET_CYC(8), .NUM_CH(3)) u_dut2 (
        .clk(clk), .rst_n(rst2_n), .en(en2), .cfg_rng(cfg_rng2), .cfg_sgl(1'b0),
        .ncs(ncs2), .adc_sclk(sclk2), .adc_addr(addr2), .rng(rng2), .sgl(sgl2),
        .douta(douta2), .doutb(doutb2), .result_valid(rv2),
        .result_addr(raddr2), .result_a(ra2), .result_b(rb2),
        .mismatch(mis2)
    );

    // ---------------- ADC model ----------------
    logic [11:0] din_a [8];
    logic [11:0] din_b [8];
    logic        corrupt = 1'b0;

    logic [31:0] wa, wb, wa2, wb2;
    int          fcnt  = 0;
    int          fcnt2 = 0;

    // ncs falling loads the frame and presents bit 31; each SCLK fall presents the next bit.
    always @(negedge ncs or negedge adc_sclk) begin
        if (adc_sclk) begin
            wa = {2'b00, din_a[adc_addr], 4'h0, din_b[adc_addr], 2'b00};
            wb = {2'b00, din_b[adc_addr], 4'h0, din_a[adc_addr], 2'b00};
            if (corrupt) wb[5] = ~wb[5];
            fcnt = 0;
        end else if (!ncs) begin
            wa   = wa << 1;
            wb   = wb << 1;
            fcnt = fcnt + 1;
        end
        douta = wa[31];
        doutb = wb[31];
    end

    always @(negedge ncs2 or negedge sclk2) begin
        if (sclk2) begin
            wa2   = {2'b00, din_a[addr2], 4'h0, din_b[addr2], 2'b00};
            wb2   = {2'b00, din_b[addr2], 4'h0, din_a[addr2], 2'b00};
            fcnt2 = 0;
        end else if (!ncs2) begin
            wa2   = wa2 << 1;
            wb2   = wb2 << 1;
            fcnt2 = fcnt2 + 1;
        end
        douta2 = wa2[31];
        doutb2 = wb2[31];
    end

    // ---------------- monitors ----------------
    typedef struct packed {
        logic [2:0]  addr;
        logic [11:0] a;
        logic [11:0] b;
        logic        mis;
        logic [31:0] cyc;
    } res_t;

    res_t q1[$];
    res_t q2[$];
    int   cyc = 0;
    int   low1 = 0, last_low1 = 0, last_falls1 = 0, held_bad1 = 0;
    int   low2 = 0, last_low2 = 0, last_falls2 = 0, held_bad2 = 0;
    logic ncs1_p = 1'b1, rng1_p = 1'b0, sgl1_p = 1'b0;
    logic ncs2_p = 1'b1, rng2_p = 1'b0;
    logic [2:0] addr1_p = '0, addr2_p = '0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (result_valid) q1.push_back('{result_addr, result_a, result_b, mismatch, 32'(cyc)});
        if (rv2)          q2.push_back('{raddr2, ra2, rb2, mis2, 32'(cyc)});

        if (!ncs) low1 <= low1 + 1;
        else if (low1 != 0) begin
            last_low1   <= low1;
            last_falls1 <= fcnt;
            low1        <= 0;
        end
        if (!ncs2) low2 <= low2 + 1;
        else if (low2 != 0) begin
            last_low2   <= low2;
            last_falls2 <= fcnt2;
            low2        <= 0;
        end

        // address / range / mode must hold for the whole chip-select window
        if (!ncs && !ncs1_p && (rng != rng1_p || sgl != sgl1_p || adc_addr != addr1_p))
            held_bad1 <= held_bad1 + 1;
        if (!ncs2 && !ncs2_p && (rng2 != rng2_p || addr2 != addr2_p))
            held_bad2 <= held_bad2 + 1;
        ncs1_p  <= ncs;  rng1_p <= rng;  sgl1_p <= sgl;  addr1_p <= adc_addr;
        ncs2_p  <= ncs2; rng2_p <= rng2; addr2_p <= addr2;
    end

    // ---------------- checking ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic get_res(input bit second, output res_t r);
        int n = 0;
        r = '0;
        while (((second ? q2.size() : q1.size()) == 0) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if ((second ? q2.size() : q1.size()) == 0) check("result_timeout", 32'd0, 32'd1);
        else r = second ? q2.pop_front() : q1.pop_front();
    endtask

    task automatic wait_ncs_low(input bit second);
        int n = 0;
        while ((second ? ncs2 : ncs) !== 1'b0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if ((second ? ncs2 : ncs) !== 1'b0) check("ncs_low_timeout", 32'd0, 32'd1);
    endtask

    // returns just after the clock edge that produced SCLK fall number n
    task automatic wait_falls(input int nf);
        int n = 0;
        while (fcnt < nf && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (fcnt < nf) check("sclk_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    logic [11:0] ea [3];
    logic [11:0] eb [3];

    initial begin
        res_t r;
        int   prev_cyc;
        int   bad;

        ea[0] = 12'hFFF; eb[0] = 12'h000;
        ea[1] = 12'h000; eb[1] = 12'hFFF;
        ea[2] = 12'hA5A; eb[2] = 12'h5A5;

        rst_n = 1'b0; rst2_n = 1'b0;
        en = 1'b0; en2 = 1'b0;
        cfg_rng = 1'b0; cfg_sgl = 1'b0; cfg_rng2 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            din_a[k] = 12'h100 + 12'(k);
            din_b[k] = 12'h200 + 12'(k);
        end

        // reset state
        repeat (3) @(negedge clk);
        check("rst_ncs", ncs, 1);
        check("rst_sclk", adc_sclk, 1);
        check("rst_addr", adc_addr, 0);
        check("rst_rng", rng, 0);
        check("rst_sgl", sgl, 0);
        check("rst_valid", result_valid, 0);
        check("rst_result", {result_addr, result_a, result_b, mismatch}, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_ncs", ncs, 1);

        // start: ncs falls one clk after en, rng/sgl latched
        cfg_rng = 1'b1; cfg_sgl = 1'b1; en = 1'b1;
        @(negedge clk);
        check("start_latency", ncs, 0);
        check("rng_latched", rng, 1);
        check("sgl_latched", sgl, 1);
        cfg_rng = 1'b0;   // must not reach rng until the next frame start

        // six-channel scan
        prev_cyc = 0;
        for (int k = 0; k < 6; k++) begin
            get_res(0, r);
            check("scan_addr", r.addr, 32'(k));
            check("scan_a", r.a, 32'h100 + 32'(k));
            check("scan_b", r.b, 32'h200 + 32'(k));
            check("scan_mis", r.mis, 0);
            if (k > 0) check("frame_period", r.cyc - prev_cyc, 138);
            prev_cyc = r.cyc;
            if (k == 0) begin
                @(negedge clk);
                check("ncs_low_len", last_low1, 130);
                check("sclk_falls", last_falls1, 32);
                check("rng_held", rng, 1);
            end
        end

        // extreme data patterns
        for (int p = 0; p < 3; p++) begin
            for (int k = 0; k < 8; k++) begin
                din_a[k] = ea[p];
                din_b[k] = eb[p];
            end
            get_res(0, r);
            check("edge_a", r.a, 32'(ea[p]));
            check("edge_b", r.b, 32'(eb[p]));
            check("edge_mis", r.mis, 0);
        end

        // corrupted second-half copy on one frame only
        for (int k = 0; k < 8; k++) begin
            din_a[k] = 12'h100 + 12'(k);
            din_b[k] = 12'h200 + 12'(k);
        end
        corrupt = 1'b1;
        get_res(0, r);
        corrupt = 1'b0;
        check("corrupt_mis", r.mis, 1);
        check("corrupt_a", r.a, 32'h100 + 32'(r.addr));
        check("corrupt_b", r.b, 32'h200 + 32'(r.addr));
        get_res(0, r);
        check("clean_mis", r.mis, 0);

        // drop en mid-frame on channel 3
        for (int i = 0; i < 8 && r.addr != 3'd2; i++) get_res(0, r);
        check("pre_drop_addr", r.addr, 2);
        wait_ncs_low(0);
        wait_falls(10);
        en = 1'b0;
        get_res(0, r);
        check("drop_addr", r.addr, 3);
        check("drop_a", r.a, 32'h103);
        check("drop_mis", r.mis, 0);
        bad = 0;
        repeat (30) begin
            @(negedge clk);
            if (ncs !== 1'b1) bad++;
        end
        check("drop_idle_ncs", bad, 0);
        check("drop_next_addr", adc_addr, 4);
        check("drop_no_result", q1.size(), 0);
        en = 1'b1;
        @(negedge clk);
        check("restart_latency", ncs, 0);
        get_res(0, r);
        check("restart_addr", r.addr, 4);
        check("restart_b", r.b, 32'h204);

        // reset in the middle of a frame
        q1.delete();
        wait_ncs_low(0);
        wait_falls(20);
        rst_n = 1'b0;
        #1;
        check("arst_ncs", ncs, 1);
        check("arst_sclk", adc_sclk, 1);
        repeat (4) @(negedge clk);
        check("arst_addr", adc_addr, 0);
        check("arst_no_result", q1.size(), 0);
        check("arst_result_addr", result_addr, 0);
        rst_n = 1'b1;
        get_res(0, r);
        check("post_rst_addr", r.addr, 0);
        check("post_rst_a", r.a, 32'h100);
        check("post_rst_b", r.b, 32'h200);
        check("post_rst_mis", r.mis, 0);

        // CLK_DIV=1, NUM_CH=3 with range toggling mid-frame
        rst2_n = 1'b1;
        @(negedge clk);
        en2 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_ncs_low(1);
            check("fast_rng_latch", rng2, cfg_rng2);
            repeat (20) @(negedge clk);
            cfg_rng2 = ~cfg_rng2;
            get_res(1, r);
            check("fast_addr", r.addr, 32'(i % 3));
            check("fast_a", r.a, 32'h100 + 32'(i % 3));
            check("fast_b", r.b, 32'h200 + 32'(i % 3));
            check("fast_mis", r.mis, 0);
        end
        @(negedge clk);
        check("fast_ncs_low_len", last_low2, 65);
        check("fast_sclk_falls", last_falls2, 32);
        check("fast_pins_held", held_bad2, 0);
        check("pins_held", held_bad1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
